// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int CNT_W           = 6;
  localparam int MUL_LATENCY_DEF = 3;
  localparam int DIV_LATENCY_DEF = 33;

  typedef enum logic [1:0] {
    ST_RUN           = 2'd0,
    ST_MULDIV        = 2'd1,
    ST_REDIRECT_WAIT = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_redirect;
    logic ifid_hold;
    logic idex_hold;
    logic exmem_hold;
    logic memwb_hold;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic muldiv_busy;
  } ctrl_t;

  // All-zero control word: nothing loads, nothing holds, nothing flushes.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // Countdown preload for an EX occupancy of lat cycles; 0 means no stall.
  function automatic logic [CNT_W-1:0] latency_load(input int lat);
    return (lat > 1) ? CNT_W'(lat - 1) : '0;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-source and pipeline-control bundle between the datapath (master)
// and the stall/flush sequencer (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int XLEN = 32
);
  logic            IMEM_BUSYWAIT;
  logic            DMEM_BUSYWAIT;
  logic [4:0]      ID_RS1;
  logic [4:0]      ID_RS2;
  logic            ID_USES_RS1;
  logic            ID_USES_RS2;
  logic            EX_MEM_READ;
  logic [4:0]      EX_RD;
  logic            EX_MULDIV;
  logic            EX_IS_DIV;
  logic            EX_BRANCH_TAKEN;
  logic [XLEN-1:0] EX_TARGET;

  logic            PC_WRITE;
  logic            PC_REDIRECT;
  logic [XLEN-1:0] PC_TARGET;
  logic            IFID_HOLD;
  logic            IDEX_HOLD;
  logic            EXMEM_HOLD;
  logic            MEMWB_HOLD;
  logic            IFID_FLUSH;
  logic            IDEX_FLUSH;
  logic            EXMEM_FLUSH;
  logic            MULDIV_BUSY;
  logic [31:0]     STALL_CNT;
  logic [31:0]     FLUSH_CNT;

  modport master (
    output IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
           EX_MEM_READ, EX_RD, EX_MULDIV, EX_IS_DIV, EX_BRANCH_TAKEN, EX_TARGET,
    input  PC_WRITE, PC_REDIRECT, PC_TARGET, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD,
           MEMWB_HOLD, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MULDIV_BUSY,
           STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  IMEM_BUSYWAIT, DMEM_BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2,
           EX_MEM_READ, EX_RD, EX_MULDIV, EX_IS_DIV, EX_BRANCH_TAKEN, EX_TARGET,
    output PC_WRITE, PC_REDIRECT, PC_TARGET, IFID_HOLD, IDEX_HOLD, EXMEM_HOLD,
           MEMWB_HOLD, IFID_FLUSH, IDEX_FLUSH, EXMEM_FLUSH, MULDIV_BUSY,
           STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipe_cycle_counter.sv
// Loadable saturating down-counter; last_o flags a count of 0 or 1.
module pipe_cycle_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         srst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         freeze_i,
  output logic         last_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (!freeze_i && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign last_o = (count_q <= W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = MUL_LATENCY_DEF,
  parameter int DIV_LATENCY = DIV_LATENCY_DEF
) (
  input logic                  CLK,
  input logic                  RESET,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [CNT_W-1:0] MUL_LOAD   = latency_load(MUL_LATENCY);
  localparam logic [CNT_W-1:0] DIV_LOAD   = latency_load(DIV_LATENCY);
  localparam bit               MUL_STALLS = (MUL_LATENCY > 1);
  localparam bit               DIV_STALLS = (DIV_LATENCY > 1);

  state_e          state_q;
  logic [XLEN-1:0] target_q;
  ctrl_t           ctrl;
  logic [XLEN-1:0] pc_target;
  logic            load_use;
  logic            muldiv_start;
  logic            cnt_load;
  logic            cnt_last;

  assign load_use = hz.EX_MEM_READ && (hz.EX_RD != 5'd0) &&
                    ((hz.ID_USES_RS1 && (hz.ID_RS1 == hz.EX_RD)) ||
                     (hz.ID_USES_RS2 && (hz.ID_RS2 == hz.EX_RD)));

  assign muldiv_start = hz.EX_MULDIV && (hz.EX_IS_DIV ? DIV_STALLS : MUL_STALLS);

  // A taken branch squashes the mul/div in EX, so it never starts the countdown.
  assign cnt_load = !RESET && !hz.DMEM_BUSYWAIT && (state_q == ST_RUN) &&
                    !hz.EX_BRANCH_TAKEN && muldiv_start;

  pipe_cycle_counter #(.W(CNT_W)) u_cnt (
    .clk        (CLK),
    .srst       (RESET),
    .load_i     (cnt_load),
    .load_val_i (hz.EX_IS_DIV ? DIV_LOAD : MUL_LOAD),
    .freeze_i   (state_q != ST_MULDIV),
    .last_o     (cnt_last)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= ST_RUN;
      target_q <= '0;
    end else if (!hz.DMEM_BUSYWAIT) begin
      case (state_q)
        ST_RUN: begin
          if (hz.EX_BRANCH_TAKEN) begin
            if (hz.IMEM_BUSYWAIT) begin
              state_q  <= ST_REDIRECT_WAIT;
              target_q <= hz.EX_TARGET;
            end
          end else if (muldiv_start) begin
            state_q <= ST_MULDIV;
          end
        end
        ST_MULDIV: begin
          if (cnt_last) state_q <= ST_RUN;
        end
        ST_REDIRECT_WAIT: begin
          if (!hz.IMEM_BUSYWAIT) state_q <= ST_RUN;
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    pc_target = '0;
    if (RESET) begin
      ctrl.ifid_flush  = 1'b1;
      ctrl.idex_flush  = 1'b1;
      ctrl.exmem_flush = 1'b1;
    end else if (hz.DMEM_BUSYWAIT) begin
      ctrl.ifid_hold   = 1'b1;
      ctrl.idex_hold   = 1'b1;
      ctrl.exmem_hold  = 1'b1;
      ctrl.memwb_hold  = 1'b1;
      ctrl.muldiv_busy = (state_q == ST_MULDIV);
    end else begin
      case (state_q)
        ST_MULDIV: begin
          ctrl.ifid_hold   = 1'b1;
          ctrl.idex_hold   = 1'b1;
          ctrl.exmem_flush = 1'b1;
          ctrl.muldiv_busy = 1'b1;
        end
        ST_REDIRECT_WAIT: begin
          ctrl.ifid_flush = 1'b1;
          ctrl.idex_flush = 1'b1;
          if (!hz.IMEM_BUSYWAIT) begin
            ctrl.pc_write    = 1'b1;
            ctrl.pc_redirect = 1'b1;
            pc_target        = target_q;
          end
        end
        default: begin
          if (hz.EX_BRANCH_TAKEN) begin
            ctrl.ifid_flush = 1'b1;
            ctrl.idex_flush = 1'b1;
            if (!hz.IMEM_BUSYWAIT) begin
              ctrl.pc_write    = 1'b1;
              ctrl.pc_redirect = 1'b1;
              pc_target        = hz.EX_TARGET;
            end
          end else if (muldiv_start) begin
            ctrl.ifid_hold   = 1'b1;
            ctrl.idex_hold   = 1'b1;
            ctrl.exmem_flush = 1'b1;
            ctrl.muldiv_busy = 1'b1;
          end else if (load_use) begin
            ctrl.ifid_hold  = 1'b1;
            ctrl.idex_flush = 1'b1;
          end else if (hz.IMEM_BUSYWAIT) begin
            ctrl.ifid_flush = 1'b1;
          end else begin
            ctrl.pc_write = 1'b1;
          end
        end
      endcase
    end
  end

  assign hz.PC_WRITE    = ctrl.pc_write;
  assign hz.PC_REDIRECT = ctrl.pc_redirect;
  assign hz.PC_TARGET   = pc_target;
  assign hz.IFID_HOLD   = ctrl.ifid_hold;
  assign hz.IDEX_HOLD   = ctrl.idex_hold;
  assign hz.EXMEM_HOLD  = ctrl.exmem_hold;
  assign hz.MEMWB_HOLD  = ctrl.memwb_hold;
  assign hz.IFID_FLUSH  = ctrl.ifid_flush;
  assign hz.IDEX_FLUSH  = ctrl.idex_flush;
  assign hz.EXMEM_FLUSH = ctrl.exmem_flush;
  assign hz.MULDIV_BUSY = ctrl.muldiv_busy;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!ctrl.pc_write) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (ctrl.ifid_flush || ctrl.idex_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign hz.STALL_CNT = stall_cnt_q;
  assign hz.FLUSH_CNT = flush_cnt_q;
`else
  assign hz.STALL_CNT = '0;
  assign hz.FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: single-cycle vector table
// plus multi-cycle sequences, compared through an expected-value queue.
module tb_pipeline_hazard_ctrl;

  typedef struct {
    logic        rst, imem, dmem;
    logic [4:0]  rs1, rs2;
    logic        use1, use2, mrd;
    logic [4:0]  rd;
    logic        md, isdiv, br;
    logic [31:0] tgt;
  } stim_t;

  typedef struct packed {
    logic        pcw;
    logic        redir;
    logic [31:0] tgt;
    logic [3:0]  hold;   // ifid, idex, exmem, memwb
    logic [2:0]  flush;  // ifid, idex, exmem
    logic        busy;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
    string nm;
  } vec_t;

`ifdef PIPE_PERF_CNT_EN
  localparam int STALL_DELTA = 4;
  localparam int FLUSH_DELTA = 5;
`else
  localparam int STALL_DELTA = 0;
  localparam int FLUSH_DELTA = 0;
`endif

  logic CLK;
  logic RESET;
  pipeline_hazard_ctrl_if #(.XLEN(32)) hz_if ();

  pipeline_hazard_ctrl #(.XLEN(32), .MUL_LATENCY(3), .DIV_LATENCY(33)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .hz    (hz_if.slave)
  );

  always #5 CLK = ~CLK;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb_q[$];
  logic [31:0] last_stall;
  logic [31:0] last_flush;

  function automatic exp_t mk(input logic pcw, input logic redir, input logic [31:0] tgt,
                              input logic [3:0] hold, input logic [2:0] flush, input logic busy);
    exp_t e;
    e.pcw = pcw; e.redir = redir; e.tgt = tgt; e.hold = hold; e.flush = flush; e.busy = busy;
    return e;
  endfunction

  function automatic stim_t st(input logic rst, input logic imem, input logic dmem,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic use1, input logic use2, input logic mrd,
                               input logic [4:0] rd, input logic md, input logic isdiv,
                               input logic br, input logic [31:0] tgt);
    stim_t s;
    s.rst = rst; s.imem = imem; s.dmem = dmem; s.rs1 = rs1; s.rs2 = rs2;
    s.use1 = use1; s.use2 = use2; s.mrd = mrd; s.rd = rd;
    s.md = md; s.isdiv = isdiv; s.br = br; s.tgt = tgt;
    return s;
  endfunction

  function automatic exp_t e_redir(input logic [31:0] t);
    return mk(1'b1, 1'b1, t, 4'b0000, 3'b110, 1'b0);
  endfunction

  exp_t E_NORM, E_RST, E_LU, E_IMEM, E_MD, E_DMEM, E_DMEM_MD, E_BRW;
  stim_t S_IDLE, S_RST, S_MUL, S_DIV, S_DMEM, S_IMEM;

  task automatic drive(input stim_t s);
    RESET                 = s.rst;
    hz_if.IMEM_BUSYWAIT   = s.imem;
    hz_if.DMEM_BUSYWAIT   = s.dmem;
    hz_if.ID_RS1          = s.rs1;
    hz_if.ID_RS2          = s.rs2;
    hz_if.ID_USES_RS1     = s.use1;
    hz_if.ID_USES_RS2     = s.use2;
    hz_if.EX_MEM_READ     = s.mrd;
    hz_if.EX_RD           = s.rd;
    hz_if.EX_MULDIV       = s.md;
    hz_if.EX_IS_DIV       = s.isdiv;
    hz_if.EX_BRANCH_TAKEN = s.br;
    hz_if.EX_TARGET       = s.tgt;
  endtask

  task automatic step(input stim_t s, input exp_t e, input string nm);
    exp_t want, got;
    drive(s);
    sb_q.push_back(e);
    @(negedge CLK);
    want      = sb_q.pop_front();
    got.pcw   = hz_if.PC_WRITE;
    got.redir = hz_if.PC_REDIRECT;
    // PC_TARGET only has a defined value while redirecting or in reset.
    got.tgt   = (want.redir || s.rst) ? hz_if.PC_TARGET : want.tgt;
    got.hold  = {hz_if.IFID_HOLD, hz_if.IDEX_HOLD, hz_if.EXMEM_HOLD, hz_if.MEMWB_HOLD};
    got.flush = {hz_if.IFID_FLUSH, hz_if.IDEX_FLUSH, hz_if.EXMEM_FLUSH};
    got.busy  = hz_if.MULDIV_BUSY;
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got pcw=%b redir=%b tgt=%h hold=%b flush=%b busy=%b, want pcw=%b redir=%b tgt=%h hold=%b flush=%b busy=%b",
               nm, got.pcw, got.redir, got.tgt, got.hold, got.flush, got.busy,
               want.pcw, want.redir, want.tgt, want.hold, want.flush, want.busy);
    end else begin
      $display("ok   %s: pcw=%b redir=%b tgt=%h hold=%b flush=%b busy=%b",
               nm, got.pcw, got.redir, got.tgt, got.hold, got.flush, got.busy);
    end
    last_stall = hz_if.STALL_CNT;
    last_flush = hz_if.FLUSH_CNT;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end else begin
      $display("ok   %s: %0d", nm, got);
    end
  endtask

  vec_t tbl[13];

  initial begin
    logic [31:0] s0, f0;

    E_NORM    = mk(1'b1, 1'b0, 32'h0, 4'b0000, 3'b000, 1'b0);
    E_RST     = mk(1'b0, 1'b0, 32'h0, 4'b0000, 3'b111, 1'b0);
    E_LU      = mk(1'b0, 1'b0, 32'h0, 4'b1000, 3'b010, 1'b0);
    E_IMEM    = mk(1'b0, 1'b0, 32'h0, 4'b0000, 3'b100, 1'b0);
    E_MD      = mk(1'b0, 1'b0, 32'h0, 4'b1100, 3'b001, 1'b1);
    E_DMEM    = mk(1'b0, 1'b0, 32'h0, 4'b1111, 3'b000, 1'b0);
    E_DMEM_MD = mk(1'b0, 1'b0, 32'h0, 4'b1111, 3'b000, 1'b1);
    E_BRW     = mk(1'b0, 1'b0, 32'h0, 4'b0000, 3'b110, 1'b0);

    S_IDLE = st(0,0,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0);
    S_RST  = st(1,0,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0);
    S_MUL  = st(0,0,0, 5'd0,5'd0, 0,0,0, 5'd7, 1,0,0, 32'h0);
    S_DIV  = st(0,0,0, 5'd0,5'd0, 0,0,0, 5'd7, 1,1,0, 32'h0);
    S_DMEM = st(0,0,1, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0);
    S_IMEM = st(0,1,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0);

    //                  rst imem dmem rs1   rs2   u1 u2 rd  exrd  md dv br target
    tbl[0]  = '{st(1,0,0, 5'd0, 5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0),   E_RST,  "reset"};
    tbl[1]  = '{st(0,0,0, 5'd1, 5'd2, 1,1,0, 5'd3, 0,0,0, 32'h0),   E_NORM, "idle"};
    tbl[2]  = '{st(0,0,0, 5'd5, 5'd1, 1,1,1, 5'd5, 0,0,0, 32'h0),   E_LU,   "lu_rs1"};
    tbl[3]  = '{st(0,0,0, 5'd5, 5'd1, 1,1,0, 5'd5, 0,0,0, 32'h0),   E_NORM, "no_load"};
    tbl[4]  = '{st(0,0,0, 5'd0, 5'd0, 1,1,1, 5'd0, 0,0,0, 32'h0),   E_NORM, "rd_x0"};
    tbl[5]  = '{st(0,0,0, 5'd4, 5'd9, 1,1,1, 5'd9, 0,0,0, 32'h0),   E_LU,   "lu_rs2"};
    tbl[6]  = '{st(0,0,0, 5'd4, 5'd9, 1,0,1, 5'd9, 0,0,0, 32'h0),   E_NORM, "rs2_unused"};
    tbl[7]  = '{st(0,1,0, 5'd0, 5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0),   E_IMEM, "imem_busy"};
    tbl[8]  = '{st(0,1,0, 5'd5, 5'd1, 1,1,1, 5'd5, 0,0,0, 32'h0),   E_LU,   "lu_over_imem"};
    tbl[9]  = '{st(0,0,0, 5'd0, 5'd0, 0,0,0, 5'd0, 0,0,1, 32'h100), e_redir(32'h100), "br_taken"};
    tbl[10] = '{st(0,0,1, 5'd0, 5'd0, 0,0,0, 5'd0, 0,0,0, 32'h0),   E_DMEM, "dmem_busy"};
    tbl[11] = '{st(0,0,1, 5'd5, 5'd1, 1,1,1, 5'd5, 0,0,1, 32'h80),  E_DMEM, "dmem_over_all"};
    tbl[12] = '{st(0,0,0, 5'd5, 5'd1, 1,1,1, 5'd5, 0,0,1, 32'h44),  e_redir(32'h44), "br_over_lu"};

    CLK = 1'b0;
    drive(S_RST);
    #1;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].s, tbl[i].e, tbl[i].nm);
      if (i == 1) chk32("stall_cnt_after_reset", last_stall, 32'd0);
    end

    // MUL: 3 busy cycles (EX_MULDIV left high to show it is ignored), then RUN.
    for (int i = 0; i < 3; i++) step(S_MUL, E_MD, $sformatf("mul_busy%0d", i));
    step(S_IDLE, E_NORM, "mul_done");

    // DIV: 33 busy cycles.
    step(S_DIV, E_MD, "div_busy0");
    for (int i = 1; i < 33; i++) step(S_IDLE, E_MD, $sformatf("div_busy%0d", i));
    step(S_IDLE, E_NORM, "div_done");

    // Branch with IMEM busy for 4 cycles, then redirect to the saved target.
    step(st(0,1,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,1, 32'h200), E_BRW, "brw_0");
    s0 = last_stall;
    f0 = last_flush;
    for (int i = 1; i < 4; i++)
      step(st(0,1,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,0, 32'h999), E_BRW, $sformatf("brw_%0d", i));
    step(st(0,0,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,0, 32'h999), e_redir(32'h200), "brw_redirect");
    step(S_IDLE, E_NORM, "brw_after");
    chk32("stall_cnt_delta", last_stall - s0, STALL_DELTA);
    chk32("flush_cnt_delta", last_flush - f0, FLUSH_DELTA);

    // DMEM stall for 5 cycles in the middle of a DIV.
    step(S_DIV, E_MD, "divd_0");
    for (int i = 1; i < 3; i++) step(S_IDLE, E_MD, $sformatf("divd_%0d", i));
    for (int i = 0; i < 5; i++) step(S_DMEM, E_DMEM_MD, $sformatf("divd_dmem%0d", i));
    for (int i = 0; i < 25; i++) step(S_IDLE, E_MD, $sformatf("divd_tail%0d", i));
    step(S_IDLE, E_NORM, "divd_done");

    // Reset in cycle 2 of a DIV abandons it.
    step(S_DIV, E_MD, "divr_0");
    step(S_IDLE, E_MD, "divr_1");
    step(S_RST, E_RST, "divr_reset");
    step(S_IDLE, E_NORM, "divr_run0");
    step(S_IDLE, E_NORM, "divr_run1");

    // Reset during REDIRECT_WAIT drops the pending redirect.
    step(st(0,1,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,1, 32'h300), E_BRW, "rwr_0");
    step(S_IMEM, E_BRW, "rwr_1");
    step(S_RST, E_RST, "rwr_reset");
    step(S_IDLE, E_NORM, "rwr_run");

    // DMEM stall freezes REDIRECT_WAIT; the redirect follows the release.
    step(st(0,1,0, 5'd0,5'd0, 0,0,0, 5'd0, 0,0,1, 32'h400), E_BRW, "rwd_0");
    step(S_DMEM, E_DMEM, "rwd_dmem");
    step(S_IDLE, e_redir(32'h400), "rwd_redirect");
    step(S_IDLE, E_NORM, "rwd_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
